// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams count consecutive RAM words (latency 1 or 2) into a ready/valid output
// Ports: clk, rst_n (async active-low); go/start_addr/count launch an operation; busy/done status;
//        ram_rd_en/ram_rd_addr/ram_rd_data RAM read port; out_valid/out_ready/out_data output stream.
module ram_stream_reader #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 6,
   parameter int READ_LATENCY = 1,
   parameter int BUF_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  go,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);
   localparam int PW = $clog2(BUF_DEPTH);
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
   state_t state;
   logic [ADDR_WIDTH:0] rd_left, out_left;
   logic [READ_LATENCY-1:0] in_flight;
   logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] occ;
   logic push, pop;
   // A read still inside the RAM pipeline already owns a buffer slot, so the buffer never overflows.
   assign ram_rd_en = state == READ && int'(occ) + $countones(in_flight) < BUF_DEPTH;
   assign push      = in_flight[READ_LATENCY-1];
   assign pop       = out_valid && out_ready;
   assign out_valid = occ != '0;
   assign out_data  = out_valid ? buf_mem[rd_ptr] : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_rd_addr <= '0;
         rd_left     <= '0;
         out_left    <= '0;
      end else begin
         out_left <= out_left - (ADDR_WIDTH+1)'(pop);
         case (state)
            IDLE: if (go) begin
               state       <= count == '0 ? DONE : READ;
               busy        <= 1'b1;
               done        <= count == '0;
               ram_rd_addr <= start_addr;
               rd_left     <= count;
               out_left    <= count;
            end
            READ: if (ram_rd_en) begin
               ram_rd_addr <= ram_rd_addr + ADDR_WIDTH'(1);
               rd_left     <= rd_left - (ADDR_WIDTH+1)'(1);
               if (rd_left == (ADDR_WIDTH+1)'(1)) state <= DRAIN;
            end
            DRAIN: if (pop && out_left == (ADDR_WIDTH+1)'(1)) begin
               state <= DONE;
               done  <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   // Clearing in_flight on reset is what discards RAM data still returning from an aborted operation.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         in_flight <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
      end else begin
         in_flight <= READ_LATENCY'({in_flight, ram_rd_en});
         wr_ptr    <= wr_ptr + PW'(push);
         rd_ptr    <= rd_ptr + PW'(pop);
         occ       <= occ + (PW+1)'(push) - (PW+1)'(pop);
      end
   always_ff @(posedge clk)
      if (push) buf_mem[wr_ptr] <= ram_rd_data;
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: runs READ_LATENCY 1 and 2 readers side by side against a queue-based reference
module tb_ram_stream_reader;
   localparam int DW = 8;
   localparam int AW = 6;
   localparam int BD = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic go = 1'b0;
   logic out_ready = 1'b1;
   logic [AW-1:0] start_addr = '0;
   logic [AW:0] count = '0;
   logic [DW-1:0] ram [2**AW];
   int n_checks = 0;
   int n_errors = 0;
   bit rand_ready = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   for (genvar i = 0; i < 2; i++) begin : lat
      localparam int L = i + 1;
      logic busy, done, rd_en, out_valid;
      logic [AW-1:0] rd_addr;
      logic [DW-1:0] rd_data, out_data, r1, r2, held;
      logic [DW-1:0] exp_q[$];
      logic [AW-1:0] addr_q[$];
      bit active, done_exp, stalled, saw_valid;
      int since, pending, n_xfer, last_x, cyc;
      ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(L), .BUF_DEPTH(BD)) dut (
         .clk(clk), .rst_n(rst_n), .go(go), .start_addr(start_addr), .count(count),
         .busy(busy), .done(done), .ram_rd_en(rd_en), .ram_rd_addr(rd_addr), .ram_rd_data(rd_data),
         .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));
      always @(posedge clk) begin
         if (rd_en) r1 <= ram[rd_addr];
         r2 <= r1;
      end
      assign rd_data = L == 1 ? r1 : r2;
      always @(negedge clk) begin
         cyc++;
         if (!rst_n) begin
            exp_q.delete();
            addr_q.delete();
            active = 0;
            done_exp = 0;
            stalled = 0;
            pending = 0;
         end else begin
            if (active) since++;
            check($sformatf("L%0d_busy", L), busy, active);
            check($sformatf("L%0d_done", L), done, done_exp);
            if (done_exp) begin
               check($sformatf("L%0d_reads_left_at_done", L), addr_q.size(), 0);
               active = 0;
               done_exp = 0;
            end
            if (rd_en) begin
               check($sformatf("L%0d_rd_en_expected", L), addr_q.size() != 0, 1);
               if (addr_q.size() != 0) begin
                  check($sformatf("L%0d_rd_addr", L), rd_addr, addr_q.pop_front());
                  pending++;
               end
            end
            check($sformatf("L%0d_occupancy_le_depth", L), pending <= BD, 1);
            if (stalled) check($sformatf("L%0d_stall_stable", L), {out_valid, out_data}, {1'b1, held});
            if (out_valid) begin
               check($sformatf("L%0d_valid_expected", L), exp_q.size() != 0, 1);
               if (!saw_valid) begin
                  check($sformatf("L%0d_first_valid_latency", L), since, L + 1);
                  saw_valid = 1;
               end
               if (out_ready && exp_q.size() != 0) begin
                  check($sformatf("L%0d_out_data", L), out_data, exp_q.pop_front());
                  if (!rand_ready && n_xfer > 0) check($sformatf("L%0d_xfer_gap", L), cyc - last_x, 1);
                  n_xfer++;
                  last_x = cyc;
                  pending--;
                  if (exp_q.size() == 0) done_exp = 1;
               end
            end
            stalled = out_valid && !out_ready;
            held = out_data;
            if (go && !busy) begin
               for (int k = 0; k < int'(count); k++) begin
                  exp_q.push_back(ram[AW'(int'(start_addr) + k)]);
                  addr_q.push_back(AW'(int'(start_addr) + k));
               end
               active = 1;
               since = -1;
               saw_valid = count == 0;
               n_xfer = 0;
               done_exp = count == 0;
            end
         end
      end
   end
   initial forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
   end
   task automatic check_reset(input string tag);
      check({tag, "_L1"}, {lat[0].busy, lat[0].done, lat[0].rd_en, lat[0].out_valid, lat[0].rd_addr, lat[0].out_data}, 0);
      check({tag, "_L2"}, {lat[1].busy, lat[1].done, lat[1].rd_en, lat[1].out_valid, lat[1].rd_addr, lat[1].out_data}, 0);
   endtask
   task automatic start(input int a, input int n);
      @(posedge clk);
      #1 go = 1'b1;
      start_addr = AW'(a);
      count = (AW+1)'(n);
      @(posedge clk);
      #1 go = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((lat[0].busy || lat[1].busy) && n < 3000) begin
         @(posedge clk);
         #1 n++;
      end
      check("idle_timeout", n < 3000, 1);
      @(posedge clk);
      #1;
   endtask
   task automatic run(input int a, input int n);
      start(a, n);
      wait_idle();
   endtask
   initial begin
      int n;
      for (int a = 0; a < 2**AW; a++) ram[a] = DW'(a);
      repeat (3) @(posedge clk);
      #1 check_reset("reset_outputs");
      rst_n = 1'b1;
      run(0, 8);
      run(62, 4);
      run(7, 0);
      rand_ready = 1'b1;
      start(5, 20);
      repeat (3) @(posedge clk);
      #1 go = 1'b1;
      start_addr = AW'(40);
      count = (AW+1)'(3);
      @(posedge clk);
      #1 go = 1'b0;
      wait_idle();
      for (int a = 0; a < 2**AW; a++) ram[a] = DW'($urandom);
      run($urandom_range(0, 63), 20);
      run($urandom_range(0, 63), 20);
      rand_ready = 1'b0;
      run(0, 64);
      repeat (8) begin
         rand_ready = bit'($urandom_range(0, 1));
         run($urandom_range(0, 63), $urandom_range(1, 64));
      end
      rand_ready = 1'b0;
      start(10, 10);
      n = 0;
      while (lat[0].n_xfer < 3 && n < 500) begin
         @(posedge clk);
         n++;
      end
      check("abort_wait_timeout", n < 500, 1);
      #1 rst_n = 1'b0;
      #1 check_reset("abort_outputs");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 check_reset("after_abort_quiet");
      run(10, 10);
      rand_ready = 1'b1;
      run(33, 13);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, RAM address width in bits.
REQ-003 SHALL have parameter READ_LATENCY, default 1, cycles from ram_rd_en to valid ram_rd_data; legal values are 1 and 2 (2 = registered read data).
REQ-004 SHALL have parameter BUF_DEPTH, default 4, output buffer depth in words; legal when BUF_DEPTH >= READ_LATENCY+1 and BUF_DEPTH is a power of two.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 go  input  1  start pulse; sampled only in IDLE.
REQ-009 start_addr  input  ADDR_WIDTH  first RAM address; captured on an accepted go.
REQ-010 count  input  ADDR_WIDTH+1  number of words to read (0 to 2^ADDR_WIDTH); captured on an accepted go.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 ram_rd_en  output  1  RAM read enable.
REQ-014 ram_rd_addr  output  ADDR_WIDTH  RAM read address.
REQ-015 ram_rd_data  input  DATA_WIDTH  RAM read data, valid READ_LATENCY cycles after ram_rd_en.
REQ-016 out_valid  output  1  output word available.
REQ-017 out_ready  input  1  downstream accepts the word; a transfer occurs when out_valid and out_ready are both high.
REQ-018 out_data  output  DATA_WIDTH  output word; held stable while out_valid is high and out_ready is low.

Function
REQ-019 SHALL implement the FSM states IDLE, READ, DRAIN and DONE.
REQ-020 IDLE to READ on go when count != 0; IDLE to DONE on go when count == 0; otherwise remain in IDLE.
REQ-021 READ to DRAIN in the cycle after the final read issue; DRAIN to DONE in the cycle after the final output transfer; DONE to IDLE unconditionally after one cycle.
REQ-022 SHALL assert done only in DONE, so done is exactly one cycle wide.
REQ-023 SHALL ignore go while busy.
REQ-024 SHALL issue a read (ram_rd_en=1) in READ only when the buffer has room: outstanding reads plus buffer occupancy < BUF_DEPTH.
REQ-025 The first read SHALL use address start_addr, and each issued read SHALL increment the address by 1 modulo 2^ADDR_WIDTH (wrap-around is legal).
REQ-026 SHALL issue exactly count reads per operation, and ram_rd_en SHALL be 0 outside READ.
REQ-027 SHALL capture ram_rd_data into the buffer exactly READ_LATENCY cycles after each issue, using a READ_LATENCY-deep valid shift register.
REQ-028 The buffer SHALL be FIFO-ordered, so words are output in address order with none dropped or duplicated under any out_ready pattern.
REQ-029 SHALL reach a throughput of 1 word/cycle once the pipeline fills while out_ready is held at 1.
REQ-030 out_valid SHALL be high iff the buffer is non-empty, and the buffer SHALL support a write and a read in the same cycle.
REQ-031 The first out_valid SHALL appear READ_LATENCY+1 cycles after the go cycle.
REQ-032 done SHALL assert in the cycle after the final transfer.

Reset
REQ-033 On rst_n=0, SHALL immediately enter IDLE and force busy=0, done=0, ram_rd_en=0, out_valid=0, ram_rd_addr=0 and out_data=0.
REQ-034 On rst_n=0, SHALL clear the buffer, the in-flight shift register and the counters.
REQ-035 Reset mid-operation SHALL abort the operation with no further reads or outputs, and RAM data returning after reset SHALL be discarded.

Verification
REQ-036 RAM preloaded with mem[i]=i; go with start_addr=0, count=8, out_ready=1 -> out_data 0..7 on consecutive cycles, first out_valid at cycle READ_LATENCY+1, done pulse the cycle after the word 7 transfer.
REQ-037 start_addr=62, count=4, ADDR_WIDTH=6 -> ram_rd_addr sequence 62,63,0,1 and outputs mem[62],mem[63],mem[0],mem[1].
REQ-038 count=20, out_ready toggling randomly at 30% high, both READ_LATENCY values -> all 20 words delivered in order, occupancy never exceeds BUF_DEPTH, out_data stable while stalled.
REQ-039 go with count=0 -> no ram_rd_en, no out_valid, busy high for one cycle, done one cycle after go.
REQ-040 go asserted again while busy -> ignored; the operation completes unchanged.
REQ-041 rst_n pulsed low after 3 of 10 words are output -> all outputs zero immediately, no further out_valid or done; a new go then runs correctly from start_addr.
